hazard_unit: RTL and testbench
==============================

# hazard_unit

Stall/flush controller for the 5-stage LEGv8 pipeline. It handles the hazards that operand forwarding cannot cover:
- load-use dependencies,
- branch-in-ID dependencies on an in-flight load,
- wrong-path fetch after a taken branch,
- multi-cycle data-memory accesses.

It sits beside the forwarding logic. It drives the PC, IF/ID, ID/EX and back-end pipeline-register enables, and keeps a stall performance counter plus a sticky memory-timeout error.

## Interface
Parameters:
- MEM_TIMEOUT, 64: number of consecutive MEM_WAIT cycles after which memError is set.
- CNT_W, 16: width of stallCount.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high.
- memReadEX  input  1  instruction in EX is a load (LDUR).
- RdEX  input  5  destination register of the instruction in EX.
- Rn, Rm  input  5 each  source registers of the instruction in ID.
- useRn, useRm  input  1 each  ID instruction actually reads Rn / Rm.
- branchID  input  1  ID holds CBZ/CBNZ; the operand is resolved in ID.
- branchTaken  input  1  branch decision from the ID branch logic.
- memReqMEM  input  1  MEM stage is issuing a load or store.
- dmemReady  input  1  data memory completes the access this cycle.
- pcWrite  output  1  PC update enable.
- ifidWrite  output  1  IF/ID write enable.
- idexBubble  output  1  zero all control fields entering ID/EX.
- ifidFlush  output  1  clear IF/ID to a NOP.
- stallAll  output  1  freeze EX/MEM and MEM/WB.
- stallCount  output  CNT_W  saturating count of stall cycles.
- memError  output  1  sticky MEM_WAIT timeout.

## Operation
- The hazard match ignores register 31 (XZR): RdEX == 31 never matches.
- loadHaz = memReadEX & RdEX != 31 & ((useRn & RdEX == Rn) | (useRm & RdEX == Rm)).
- States:
  - RUN: normal operation.
  - STALL: pending bubble cycles.
  - MEM_WAIT: memory stall.
- Priority each cycle: memory wait > load hazard > flush.
- RUN:
  - memReqMEM & !dmemReady → go to MEM_WAIT. This cycle: stallAll=1, pcWrite=0, ifidWrite=0, idexBubble=0.
  - Otherwise, if loadHaz & !branchID → 1 bubble: pcWrite=0, ifidWrite=0, idexBubble=1. Stay in RUN.
  - Otherwise, if loadHaz & branchID → 2 bubbles: same outputs this cycle, load stallLeft=1, go to STALL.
  - Otherwise, if branchTaken & branchID → ifidFlush=1. PC and IF/ID stay enabled.
- STALL:
  - Outputs: pcWrite=0, ifidWrite=0, idexBubble=1. branchTaken is ignored (operand not valid yet).
  - Decrement stallLeft; at 0 → RUN.
  - A memory wait arising in STALL takes priority: go to MEM_WAIT and keep stallLeft.
- MEM_WAIT:
  - Outputs: stallAll=1, pcWrite=0, ifidWrite=0, no bubble, no flush.
  - On dmemReady: outputs still frozen for that cycle; next state is STALL if stallLeft != 0, else RUN.
  - A wait counter increments each cycle. When it reaches MEM_TIMEOUT, memError=1 (sticky) and waiting continues.
- stallCount increments every cycle in which pcWrite=0 and saturates at all-ones.
- Outputs not listed for a case take their defaults: pcWrite=1, ifidWrite=1, all other 1-bit outputs 0.

## Timing
- Hazard outputs are combinational (Mealy) from state and current inputs. No added latency: a stall is asserted in the same cycle the hazard is visible.
- State, stallLeft, the wait counter, stallCount and memError update on the rising clk edge.
- While reset is high:
  - Outputs are forced to pcWrite=1, ifidWrite=1, idexBubble=0, ifidFlush=0, stallAll=0.
  - On the edge: state=RUN, stallLeft=0, wait counter=0, stallCount=0, memError=0.
- Reset asserted mid-STALL or mid-MEM_WAIT aborts the stall immediately, with no residual bubble.
- dmemReady arriving on the same cycle as memReqMEM → no stall at all.
- The wait counter clears on every exit from MEM_WAIT.

## Structure
- Shared package hazard_pkg:
  - state enum hz_state_t {RUN, STALL, MEM_WAIT},
  - constant XZR = 5'd31, also used by the forwarding logic.
- Single module. No sub-module needed; the saturating counter is inline.

## Test plan
- Load-use, single bubble:
  - Stimulus: memReadEX=1, RdEX=5, Rn=5, useRn=1, branchID=0.
  - Response: one cycle with pcWrite=0, ifidWrite=0, idexBubble=1; next cycle (memReadEX=0) defaults; stallCount=1.
- Load feeding CBZ:
  - Stimulus: RdEX=9, Rm=9, useRm=1, branchID=1.
  - Response: two consecutive bubble cycles; branchTaken=1 during the second is ignored; ifidFlush=1 only once the branch is re-evaluated in RUN.
- XZR and unused source:
  - Stimulus: RdEX=31=Rn with useRn=1; separately RdEX=3=Rm with useRm=0.
  - Response: no stall in either case.
- Memory wait:
  - Stimulus: memReqMEM=1, dmemReady low for 3 cycles, then high.
  - Response: stallAll=1 for 4 cycles; RUN afterwards; stallCount=4; memError=0.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dmemReady held low for 6 cycles.
  - Response: memError rises after the 4th wait cycle and remains set after dmemReady; cleared only by reset.
- Reset mid-STALL:
  - Stimulus: assert reset in the first STALL cycle.
  - Response: default outputs during reset; state RUN; counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard and forwarding logic.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // X31 reads as zero, so a write to it never creates a dependency.
  localparam logic [4:0] XZR = 5'd31;

  localparam int STALL_W = 2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic stall_all;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_BUBBLE  = '{idex_bubble: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE  = '{stall_all: 1'b1, default: 1'b0};

  function automatic logic src_match(input logic use_src, input logic [4:0] rd,
                                     input logic [4:0] rs);
    return use_src && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage LEGv8 pipeline: load-use bubbles,
// branch-after-load double bubbles, taken-branch flush and data-memory wait.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memReadEX,
  input  logic [4:0]       RdEX,
  input  logic [4:0]       Rn,
  input  logic [4:0]       Rm,
  input  logic             useRn,
  input  logic             useRm,
  input  logic             branchID,
  input  logic             branchTaken,
  input  logic             memReqMEM,
  input  logic             dmemReady,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexBubble,
  output logic             ifidFlush,
  output logic             stallAll,
  output logic [CNT_W-1:0] stallCount,
  output logic             memError
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t          state_q, state_d;
  logic [STALL_W-1:0] stall_left_q, stall_left_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               load_haz, mem_wait;
  hz_ctrl_t           ctrl;

  assign load_haz = memReadEX && (RdEX != XZR) &&
                    (src_match(useRn, RdEX, Rn) || src_match(useRm, RdEX, Rm));
  assign mem_wait = memReqMEM && !dmemReady;
  // Holding at WAIT_MAX keeps a very long wait from wrapping back below the limit.
  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      stall_left_q <= '0;
      wait_q       <= '0;
      stall_cnt_q  <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      wait_q       <= wait_d;
      stall_cnt_q  <= stall_cnt_d;
      mem_err_q    <= mem_err_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    wait_d       = wait_q;
    mem_err_d    = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (load_haz && branchID) begin
          stall_left_d = STALL_W'(1);
          state_d      = STALL;
        end
      end
      STALL: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (stall_left_q <= STALL_W'(1)) begin
          stall_left_d = '0;
          state_d      = RUN;
        end else begin
          stall_left_d = stall_left_q - 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmemReady) begin
          wait_d  = '0;
          state_d = (stall_left_q != '0) ? STALL : RUN;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_MAX) mem_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    stall_cnt_d = (!ctrl.pc_write && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  // Mealy outputs; reset forces defaults so an aborted stall leaves no bubble.
  always_comb begin
    ctrl = CTRL_DEFAULT;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (mem_wait)                    ctrl = CTRL_FREEZE;
          else if (load_haz)               ctrl = CTRL_BUBBLE;
          else if (branchTaken && branchID) ctrl.ifid_flush = 1'b1;
        end
        STALL:    ctrl = mem_wait ? CTRL_FREEZE : CTRL_BUBBLE;
        MEM_WAIT: ctrl = CTRL_FREEZE;
        default:  ctrl = CTRL_DEFAULT;
      endcase
    end
  end

  assign pcWrite    = ctrl.pc_write;
  assign ifidWrite  = ctrl.ifid_write;
  assign idexBubble = ctrl.idex_bubble;
  assign ifidFlush  = ctrl.ifid_flush;
  assign stallAll   = ctrl.stall_all;
  assign stallCount = stall_cnt_q;
  assign memError   = mem_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a short timeout and narrow stall counter
// so timeout and saturation are reachable in a few cycles.
module tb_hazard_unit;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // {pcWrite, ifidWrite, idexBubble, ifidFlush, stallAll}
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] BUB = 5'b00100;
  localparam logic [4:0] FLU = 5'b11010;
  localparam logic [4:0] MEM = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  logic memReadEX, useRn, useRm, branchID, branchTaken, memReqMEM, dmemReady;
  logic [4:0] RdEX, Rn, Rm;
  logic pcWrite, ifidWrite, idexBubble, ifidFlush, stallAll, memError;
  logic [CNT_W-1:0] stallCount;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .memReadEX  (memReadEX),
    .RdEX       (RdEX),
    .Rn         (Rn),
    .Rm         (Rm),
    .useRn      (useRn),
    .useRm      (useRm),
    .branchID   (branchID),
    .branchTaken(branchTaken),
    .memReqMEM  (memReqMEM),
    .dmemReady  (dmemReady),
    .pcWrite    (pcWrite),
    .ifidWrite  (ifidWrite),
    .idexBubble (idexBubble),
    .ifidFlush  (ifidFlush),
    .stallAll   (stallAll),
    .stallCount (stallCount),
    .memError   (memError)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [4:0] exp);
    #1;
    check(tag, {27'd0, pcWrite, ifidWrite, idexBubble, ifidFlush, stallAll}, {27'd0, exp});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    memReadEX = 1'b0; RdEX = 5'd0; Rn = 5'd0; Rm = 5'd0;
    useRn = 1'b0; useRm = 1'b0; branchID = 1'b0; branchTaken = 1'b0;
    memReqMEM = 1'b0; dmemReady = 1'b0;
  endtask

  task automatic load_cbz;
    idle();
    memReadEX = 1'b1; RdEX = 5'd9; Rm = 5'd9; useRm = 1'b1; branchID = 1'b1;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset: outputs forced to defaults even with a hazard on the inputs.
    idle();
    reset = 1'b1;
    memReadEX = 1'b1; RdEX = 5'd5; Rn = 5'd5; useRn = 1'b1;
    check_ctrl("reset_outputs", DEF);
    step();
    reset = 1'b0;
    idle();
    check("reset_stallCount", 32'(stallCount), 32'd0);
    check("reset_memError", 32'(memError), 32'd0);

    // Load-use, single bubble.
    memReadEX = 1'b1; RdEX = 5'd5; Rn = 5'd5; useRn = 1'b1;
    check_ctrl("loaduse_bubble", BUB);
    step();
    idle();
    check_ctrl("loaduse_after", DEF);
    check("loaduse_count", 32'(stallCount), 32'd1);

    // Load feeding CBZ: two bubbles, branchTaken ignored in STALL, flush in RUN.
    load_cbz();
    check_ctrl("cbz_bubble1", BUB);
    step();
    idle();
    branchID = 1'b1; branchTaken = 1'b1;
    check_ctrl("cbz_bubble2", BUB);
    step();
    check_ctrl("cbz_flush", FLU);
    step();
    idle();
    check("cbz_count", 32'(stallCount), 32'd3);

    // XZR, unused source and a not-taken-by-ID branch: no stall.
    memReadEX = 1'b1; RdEX = 5'd31; Rn = 5'd31; useRn = 1'b1;
    check_ctrl("xzr_nostall", DEF);
    idle();
    memReadEX = 1'b1; RdEX = 5'd3; Rm = 5'd3; useRm = 1'b0;
    check_ctrl("unused_rm_nostall", DEF);
    idle();
    branchTaken = 1'b1;
    check_ctrl("taken_no_branchid", DEF);
    step();
    idle();
    check("nostall_count", 32'(stallCount), 32'd3);

    // Memory wait (3 low + 1 high); memory wait outranks a load hazard.
    memReqMEM = 1'b1; dmemReady = 1'b0;
    memReadEX = 1'b1; RdEX = 5'd5; Rn = 5'd5; useRn = 1'b1;
    check_ctrl("memwait_c1", MEM);
    step();
    idle();
    memReqMEM = 1'b1;
    check_ctrl("memwait_c2", MEM);
    step();
    check_ctrl("memwait_c3", MEM);
    step();
    dmemReady = 1'b1;
    check_ctrl("memwait_ready", MEM);
    step();
    idle();
    check_ctrl("memwait_after", DEF);
    check("memwait_count", 32'(stallCount), 32'd7);
    check("memwait_noerr", 32'(memError), 32'd0);

    // Ready in the same cycle as the request: no stall.
    memReqMEM = 1'b1; dmemReady = 1'b1;
    check_ctrl("mem_ready_same", DEF);
    step();
    idle();
    check("mem_ready_count", 32'(stallCount), 32'd7);

    // Memory wait arising in STALL keeps the pending bubble.
    load_cbz();
    check_ctrl("stallmem_bub1", BUB);
    step();
    idle();
    memReqMEM = 1'b1;
    check_ctrl("stallmem_freeze", MEM);
    step();
    dmemReady = 1'b1;
    check_ctrl("stallmem_ready", MEM);
    step();
    idle();
    check_ctrl("stallmem_bub2", BUB);
    step();
    check_ctrl("stallmem_run", DEF);
    check("stallmem_count", 32'(stallCount), 32'd11);

    // Timeout: error after the 4th MEM_WAIT cycle, sticky past dmemReady.
    do_reset();
    check("timeout_reset_count", 32'(stallCount), 32'd0);
    memReqMEM = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 4) check("timeout_err_before", 32'(memError), 32'd0);
      if (i == 5) check("timeout_err_rise", 32'(memError), 32'd1);
    end
    dmemReady = 1'b1;
    check_ctrl("timeout_ready", MEM);
    step();
    idle();
    check_ctrl("timeout_after", DEF);
    check("timeout_sticky", 32'(memError), 32'd1);
    check("timeout_count", 32'(stallCount), 32'd7);

    // Saturation: 10 more stall cycles push 7 past 15.
    memReqMEM = 1'b1;
    for (int i = 0; i < 9; i++) step();
    dmemReady = 1'b1;
    step();
    idle();
    check("sat_count", 32'(stallCount), 32'd15);
    memReadEX = 1'b1; RdEX = 5'd5; Rn = 5'd5; useRn = 1'b1;
    step();
    idle();
    check("sat_hold", 32'(stallCount), 32'd15);
    check("sat_err_sticky", 32'(memError), 32'd1);

    // Reset in the first STALL cycle aborts the stall.
    load_cbz();
    step();
    idle();
    reset = 1'b1;
    check_ctrl("rststall_forced", DEF);
    step();
    reset = 1'b0;
    check_ctrl("rststall_no_residual", DEF);
    check("rststall_count", 32'(stallCount), 32'd0);
    check("rststall_err", 32'(memError), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
